mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-access stage directly downstream of the microcoded controller in the multi-cycle RISC-V CPU. It consumes the controller's MemRead/MemWrite/IorD/IRWrite strobes and drives a req/ack memory bus with variable latency. It holds the instruction register (IR) and memory data register (MDR), and feeds opcode back to the controller. It raises a stall so the microprogram counter holds its state until the access completes.

Parameters:
TIMEOUT, 15, max BUSY cycles without mem_ack before abort (1..255)
ADDR_W, 32, bus address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
MemRead  in  1  controller read strobe
MemWrite  in  1  controller write strobe
IorD  in  1  0: address=pc, 1: address=alu_out
IRWrite  in  1  read data also loads IR
pc  in  32  program counter
alu_out  in  32  data address
wdata  in  32  store data (B register)
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  bus address
mem_wdata  out  32  bus write data
mem_rdata  in  32  bus read data, valid with mem_ack
mem_ack  in  1  bus completion, single-cycle pulse
stall  out  1  hold microprogram counter
instr  out  32  IR contents
opcode  out  7  instr[6:0]
mdr  out  32  MDR contents
misalign_err  out  1  sticky: misaligned access
bus_err  out  1  sticky: timeout or illegal strobe combination

Behaviour:
- Reset values: state=IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; instr, mdr = 0; errors = 0; timeout counter = 0. stall = 0 in reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE, MemRead XOR MemWrite asserted:
  - Select addr = IorD ? alu_out : pc.
  - If addr[1:0] != 0: set misalign_err; no bus access; stall = 0; stay IDLE.
  - Otherwise stall = 1 (combinational, same cycle). Latch addr, wdata, we = MemWrite, and irw = IRWrite & MemRead. Go to BUSY.
- IDLE, MemRead & MemWrite both asserted: set bus_err; no access; stall = 0; stay IDLE.
- BUSY:
  - mem_req = 1 and mem_we, mem_addr, mem_wdata are driven from latched values, held stable until ack.
  - stall = 1.
  - Counter increments each cycle.
  - On mem_ack: for a read, MDR <= mem_rdata, and IR <= mem_rdata if irw. Go to DONE. mem_req deasserts on the following cycle.
  - If the counter reaches TIMEOUT with no ack: set bus_err; MDR and IR are unchanged; mem_req drops; go to DONE.
- DONE:
  - stall = 0 for exactly one cycle, so the controller advances on this edge.
  - Strobes still asserted in DONE are ignored (same microstate); go to IDLE.
- Minimum access latency: 3 cycles from strobe to stall release with a same-cycle ack (IDLE -> BUSY, ack, DONE).
- mem_ack outside BUSY is ignored.
- instr and mdr change only on ack edges. opcode is always instr[6:0] (combinational).
- Error flags are sticky until rst.
- rst mid-BUSY: mem_req = 0 after that edge and state = IDLE. A late ack after reset is ignored.
- Counter resets to 0 on entering BUSY.

Test Plan:
- Instruction fetch: pc=0x10, MemRead=1, IorD=0, IRWrite=1; memory acks 2 cycles after req with rdata=0x00500093 -> mem_addr=0x10 and mem_we=0 while req is high; instr=0x00500093; opcode=0x13; mdr=0x00500093; stall high for 2 cycles after the strobe, low for 1 cycle in DONE.
- Store: alu_out=0x20, wdata=0xDEADBEEF, MemWrite=1, IorD=1; ack after 1 cycle -> mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF; instr and mdr unchanged; no errors.
- Load without IRWrite: IorD=1, alu_out=0x44, rdata=0x12345678 -> mdr=0x12345678, instr keeps its previous value.
- Misaligned: alu_out=0x22, MemRead=1, IorD=1 -> mem_req never asserts, stall=0, misalign_err=1 and stays 1.
- Timeout: read with no ack -> after 15 BUSY cycles bus_err=1, mem_req drops, DONE for 1 cycle, mdr unchanged; MemRead & MemWrite together also sets bus_err with no request.
- Reset mid-BUSY: assert rst 1 cycle during BUSY, then ack arrives -> mem_req=0, instr=0, mdr=0, state IDLE, ack ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage of the multi-cycle RISC-V CPU: turns controller strobes into
// req/ack bus transactions, owns IR and MDR, and stalls the microsequencer meanwhile.
module mem_access_unit #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [31:0]       pc,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [31:0]       mdr,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              irw_q, irw_d;
  logic              req_q, req_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic [31:0] sel_addr;
  logic        one_strobe;
  logic        start;

  assign sel_addr   = IorD ? alu_out : pc;
  assign one_strobe = MemRead ^ MemWrite;
  assign start      = (state_q == S_IDLE) && one_strobe && (sel_addr[1:0] == 2'b00);

  // Stall goes high in the strobe cycle itself so the microPC never advances past it.
  assign stall = ~rst & (start | (state_q == S_BUSY));

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    irw_d      = irw_q;
    req_d      = req_q;
    instr_d    = instr_q;
    mdr_d      = mdr_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;

    case (state_q)
      S_IDLE: begin
        if (MemRead && MemWrite) begin
          bus_err_d = 1'b1;
        end else if (one_strobe) begin
          if (sel_addr[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = ADDR_W'(sel_addr);
            wdata_d = wdata;
            we_d    = MemWrite;
            irw_d   = IRWrite & MemRead;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
            if (irw_q) instr_d = mem_rdata;
          end
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          bus_err_d = 1'b1;
          req_d     = 1'b0;
          state_d   = S_DONE;
        end
      end
      // Strobes still present here belong to the access just finished.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      irw_q      <= 1'b0;
      req_q      <= 1'b0;
      instr_q    <= 32'd0;
      mdr_q      <= 32'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      irw_q      <= irw_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      mdr_q      <= mdr_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = req_q & we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign instr        = instr_q;
  assign opcode       = instr_q[6:0];
  assign mdr          = mdr_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule
